// File: rtl/spi_tx.sv
// SPI mode-0 controller transmitter: serialises DATA_WIDTH bits MSB first on data_out/data_clk_out/sel_out.
// Define SPI_TX_CS_GAP_EN to hold sel_out high (busy_out still high) for DATA_CLK_PERIOD cycles after each frame.
module spi_tx #(
  parameter int DATA_WIDTH      = 8,
  parameter int DATA_CLK_PERIOD = 20
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  trigger_in,
  output logic                  data_out,
  output logic                  data_clk_out,
  output logic                  sel_out,
  output logic                  busy_out
);

  localparam int HALF = DATA_CLK_PERIOD / 2;
  localparam int HCW  = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int BCW  = $clog2(DATA_WIDTH);

`ifdef SPI_TX_CS_GAP_EN
  localparam int GCW = $clog2(DATA_CLK_PERIOD);
  typedef enum logic [1:0] {IDLE, TRANSMIT, GAP} state_t;
  logic [GCW-1:0] gap_cnt_reg;
`else
  typedef enum logic [1:0] {IDLE, TRANSMIT} state_t;
`endif

  state_t                state_reg;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [BCW-1:0]        bit_cnt_reg;
  logic [HCW-1:0]        half_cnt_reg;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      half_cnt_reg <= '0;
      data_out     <= 1'b0;
      data_clk_out <= 1'b0;
      sel_out      <= 1'b1;
      busy_out     <= 1'b0;
`ifdef SPI_TX_CS_GAP_EN
      gap_cnt_reg  <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (trigger_in) begin
            shift_reg    <= data_in;
            bit_cnt_reg  <= '0;
            half_cnt_reg <= '0;
            data_out     <= data_in[DATA_WIDTH-1];
            data_clk_out <= 1'b0;
            sel_out      <= 1'b0;
            busy_out     <= 1'b1;
            state_reg    <= TRANSMIT;
          end
        end

        TRANSMIT: begin
          if (half_cnt_reg == HCW'(HALF - 1)) begin
            half_cnt_reg <= '0;
            data_clk_out <= ~data_clk_out;
            // Only the falling toggle moves data; the rising toggle is the receiver's sample point.
            if (data_clk_out) begin
              if (bit_cnt_reg == BCW'(DATA_WIDTH - 1)) begin
                data_clk_out <= 1'b0;
                sel_out      <= 1'b1;
                data_out     <= 1'b0;
`ifdef SPI_TX_CS_GAP_EN
                gap_cnt_reg  <= '0;
                state_reg    <= GAP;
`else
                busy_out     <= 1'b0;
                state_reg    <= IDLE;
`endif
              end else begin
                shift_reg   <= shift_reg << 1;
                data_out    <= shift_reg[DATA_WIDTH-2];
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
              end
            end
          end else begin
            half_cnt_reg <= half_cnt_reg + 1'b1;
          end
        end

`ifdef SPI_TX_CS_GAP_EN
        GAP: begin
          if (gap_cnt_reg == GCW'(DATA_CLK_PERIOD - 1)) begin
            busy_out  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
          end
        end
`endif

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
